// File: rtl/mips_pkg.sv
// Shared multicycle MIPS definitions: opcodes, ALU control op codes and
// datapath mux encodings used by the main control FSM and the ALU decoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDIU = 6'b001001;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_ct_op_e;

  typedef enum logic [1:0] {
    SRC_B_REG     = 2'b00,
    SRC_B_FOUR    = 2'b01,
    SRC_B_IMM     = 2'b10,
    SRC_B_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'b00,
    PC_SRC_ALUOUT = 2'b01,
    PC_SRC_JUMP   = 2'b10
  } pc_source_e;

endpackage

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: walks fetch/decode/
// execute/memory/writeback, drives all datapath controls, counts retirements.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned MEM_WAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_ct_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instr_retired
);

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  function automatic logic is_mem(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RESET;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    illegal_d     = illegal_q;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    alu_ct_op     = ALU_OP_ADD;
    pc_source     = PC_SRC_ALU;

    unique case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRC_B_IMM_SH2;
        unique case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDIU:     state_d = S_I_EXEC;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_ct_op = ALU_OP_FUNCT;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_ct_op     = ALU_OP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PC_SRC_ALUOUT;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PC_SRC_JUMP;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

    // Wait count restarts whenever a memory state is newly entered and
    // saturates so a very long stall cannot wrap back below the limit.
    wait_d    = wait_q;
    timeout_d = timeout_q;
    if ((state_d != state_q) && is_mem(state_d)) begin
      wait_d = '0;
    end else if (is_mem(state_q) && !mem_ready && (wait_q != '1)) begin
      wait_d = wait_q + 8'd1;
    end
    if (is_mem(state_q) && !mem_ready && (wait_q == 8'(MEM_WAIT_MAX - 1))) begin
      timeout_d = 1'b1;
    end
  end

  assign illegal_op    = illegal_q;
  assign mem_timeout   = timeout_q;
  assign instr_retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: instructions are expanded
// into expected per-cycle control traces and compared every cycle.
module tb_multicycle_ctrl;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = '0;
  logic        mem_ready = 1'b0;

  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_ct_op, pc_source;
  logic        illegal_op, mem_timeout;
  logic [31:0] instr_retired;

  logic        w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write, w_ir_write;
  logic        w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a;
  logic [1:0]  w_alu_src_b, w_alu_ct_op, w_pc_source;
  logic        w_illegal_op, w_mem_timeout;
  logic [3:0]  w_instr_retired;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ct_op(alu_ct_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
    .instr_retired(instr_retired)
  );

  multicycle_ctrl #(.CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(w_pc_write), .pc_write_cond(w_pc_write_cond), .i_or_d(w_i_or_d),
    .mem_read(w_mem_read), .mem_write(w_mem_write), .ir_write(w_ir_write),
    .mem_to_reg(w_mem_to_reg), .reg_dst(w_reg_dst), .reg_write(w_reg_write),
    .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b), .alu_ct_op(w_alu_ct_op),
    .pc_source(w_pc_source), .illegal_op(w_illegal_op), .mem_timeout(w_mem_timeout),
    .instr_retired(w_instr_retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_ct_op, pc_source;
  } ov_t;

  typedef enum {P_FETCH, P_DECODE, P_MADDR, P_MRD, P_MWB, P_MWR,
                P_REXEC, P_RWB, P_IEXEC, P_IWB, P_BR, P_J} ph_e;

  typedef struct {
    ph_e        ph;
    logic [5:0] op;
    bit         rdy;
    bit         ret;
    bit         ill;
  } ent_t;

  ent_t tr[$];
  int   vectors = 0;
  int   fails   = 0;
  int   exp_ret = 0;
  bit   exp_ill = 0;
  bit   exp_to  = 0;
  int   wcnt    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Control values each step must show, straight from the state table.
  function automatic ov_t exp_out(input ph_e ph, input bit rdy);
    ov_t o = '0;
    case (ph)
      P_FETCH:  begin o.mem_read = 1; o.alu_src_b = 2'b01;
                      if (rdy) begin o.ir_write = 1; o.pc_write = 1; end end
      P_DECODE: o.alu_src_b = 2'b11;
      P_MADDR:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      P_MRD:    begin o.mem_read = 1; o.i_or_d = 1; end
      P_MWB:    begin o.reg_write = 1; o.mem_to_reg = 1; end
      P_MWR:    begin o.mem_write = 1; o.i_or_d = 1; end
      P_REXEC:  begin o.alu_src_a = 1; o.alu_ct_op = 2'b10; end
      P_RWB:    begin o.reg_write = 1; o.reg_dst = 1; end
      P_IEXEC:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      P_IWB:    o.reg_write = 1;
      P_BR:     begin o.alu_src_a = 1; o.alu_ct_op = 2'b01; o.pc_write_cond = 1;
                      o.pc_source = 2'b01; end
      P_J:      begin o.pc_write = 1; o.pc_source = 2'b10; end
      default:  o = '0;
    endcase
    return o;
  endfunction

  task automatic push(input ph_e ph, input logic [5:0] op, input bit rdy, input bit ret, input bit ill);
    ent_t e;
    e.ph = ph; e.op = op; e.rdy = rdy; e.ret = ret; e.ill = ill;
    tr.push_back(e);
  endtask

  // Expand one instruction into its cycle-by-cycle trace.
  task automatic build(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) push(P_FETCH, op, 0, 0, 0);
    push(P_FETCH, op, 1, 0, 0);
    case (op)
      OP_LW: begin
        push(P_DECODE, op, 1'($urandom), 0, 0);
        push(P_MADDR, op, 1'($urandom), 0, 0);
        for (int i = 0; i < mw; i++) push(P_MRD, op, 0, 0, 0);
        push(P_MRD, op, 1, 0, 0);
        push(P_MWB, op, 1'($urandom), 1, 0);
      end
      OP_SW: begin
        push(P_DECODE, op, 1'($urandom), 0, 0);
        push(P_MADDR, op, 1'($urandom), 0, 0);
        for (int i = 0; i < mw; i++) push(P_MWR, op, 0, 0, 0);
        push(P_MWR, op, 1, 1, 0);
      end
      OP_RTYPE: begin
        push(P_DECODE, op, 1'($urandom), 0, 0);
        push(P_REXEC, op, 1'($urandom), 0, 0);
        push(P_RWB, op, 1'($urandom), 1, 0);
      end
      OP_ADDIU: begin
        push(P_DECODE, op, 1'($urandom), 0, 0);
        push(P_IEXEC, op, 1'($urandom), 0, 0);
        push(P_IWB, op, 1'($urandom), 1, 0);
      end
      OP_BEQ: begin
        push(P_DECODE, op, 1'($urandom), 0, 0);
        push(P_BR, op, 1'($urandom), 1, 0);
      end
      OP_J: begin
        push(P_DECODE, op, 1'($urandom), 0, 0);
        push(P_J, op, 1'($urandom), 1, 0);
      end
      default: push(P_DECODE, op, 1'($urandom), 0, 1);
    endcase
  endtask

  function automatic ov_t act_out();
    ov_t o;
    o = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
         mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_ct_op, pc_source};
    return o;
  endfunction

  task automatic chk_state();
    chk("instr_retired", instr_retired, 32'(exp_ret));
    chk("instr_retired_w4", {28'd0, w_instr_retired}, {28'd0, 4'(exp_ret)});
    chk("illegal_op", {31'd0, illegal_op}, {31'd0, exp_ill});
    chk("mem_timeout", {31'd0, mem_timeout}, {31'd0, exp_to});
  endtask

  // Called just after a rising edge; consumes up to n trace entries.
  task automatic run_trace(input int n);
    int k = 0;
    while (tr.size() > 0 && k < n) begin
      ent_t e = tr.pop_front();
      bit memph = (e.ph == P_FETCH) || (e.ph == P_MRD) || (e.ph == P_MWR);
      opcode    = (e.ph == P_FETCH) ? 6'($urandom) : e.op;
      mem_ready = e.rdy;
      #1;
      chk("controls", {16'd0, act_out()}, {16'd0, exp_out(e.ph, e.rdy)});
      chk_state();
      if (e.ret) exp_ret++;
      if (e.ill) exp_ill = 1;
      if (memph && !e.rdy) begin
        wcnt++;
        if (wcnt == 255) exp_to = 1;
      end else begin
        wcnt = 0;
      end
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    exp_ret = 0; exp_ill = 0; exp_to = 0; wcnt = 0;
    #1;
    chk("reset_controls", {16'd0, act_out()}, 32'd0);
    chk_state();
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("reset_release_controls", {16'd0, act_out()}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] rand_op(input bit allow_illegal);
    logic [5:0] ops[6] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDIU};
    logic [5:0] r;
    if (allow_illegal && ($urandom_range(0, 7) == 0)) begin
      do r = 6'($urandom);
      while (r inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDIU});
      return r;
    end
    return ops[$urandom_range(0, 5)];
  endfunction

  initial begin
    #2;
    do_reset();

    // Directed instructions with literal latency and count pins.
    build(OP_RTYPE, 0, 0);
    chk("lat_rtype", tr.size(), 4);
    run_trace(100);
    chk("retired_after_r", instr_retired, 32'd1);
    build(OP_LW, 0, 3);
    chk("lat_lw_3wait", tr.size(), 8);
    run_trace(100);
    build(OP_LW, 0, 0);
    chk("lat_lw", tr.size(), 5);
    run_trace(100);
    build(OP_SW, 0, 0);
    chk("lat_sw", tr.size(), 4);
    run_trace(100);
    build(OP_BEQ, 0, 0);
    chk("lat_beq", tr.size(), 3);
    run_trace(100);
    build(OP_J, 0, 0);
    chk("lat_j", tr.size(), 3);
    run_trace(100);
    chk("retired_after_j", instr_retired, 32'd6);
    build(6'b111111, 0, 0);
    run_trace(100);
    chk("illegal_sticky", {31'd0, illegal_op}, 32'd1);
    chk("retired_after_illegal", instr_retired, 32'd6);
    build(OP_ADDIU, 1, 0);
    run_trace(100);

    for (int i = 0; i < 40; i++) begin
      build(rand_op(1), $urandom_range(0, 3), $urandom_range(0, 3));
      run_trace(1000);
    end

    // Reset in the middle of a stalled load read.
    build(OP_LW, 0, 6);
    run_trace(5);
    tr.delete();
    do_reset();

    for (int i = 0; i < 15; i++) begin
      build(rand_op(0), $urandom_range(0, 2), $urandom_range(0, 2));
      run_trace(1000);
    end
    chk("w4_at_max", {28'd0, w_instr_retired}, 32'd15);
    build(OP_J, 0, 0);
    run_trace(100);
    chk("w4_wrap", {28'd0, w_instr_retired}, 32'd0);
    chk("retired_16", instr_retired, 32'd16);

    // Long fetch stall: timeout raised, fetch keeps waiting.
    build(OP_RTYPE, 300, 0);
    run_trace(254);
    chk("no_timeout_254", {31'd0, mem_timeout}, 32'd0);
    run_trace(1);
    chk("timeout_255", {31'd0, mem_timeout}, 32'd1);
    run_trace(1000);
    for (int i = 0; i < 5; i++) begin
      build(rand_op(1), $urandom_range(0, 2), $urandom_range(0, 2));
      run_trace(1000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
